// File: rtl/eth_rx_dispatch.sv
// eth_rx_dispatch
// ---------------------------------------------------------------------------
// Receives the 36-bit GEMAC RX FIFO stream on sys_clk. The first four words
// of each frame (the 14-byte Ethernet header) are buffered. The EtherType is
// then compared with a runtime value, and the frame is replayed unchanged to
// one of two outputs:
//   out0 - CPU / default path
//   out1 - frames whose EtherType matches match_ethertype (when match_en = 1)
// Runt frames (too short to carry a complete EtherType) and words that arrive
// outside a frame (orphans) are dropped.
//
// Word format: [31:0] data (byte0 in [31:24]), [32] sof, [33] eof,
//              [35:34] occ (0 = 4 bytes, 1..3 = byte count, on eof only)
//
// Ports:
//   clk, reset           sys_clk and asynchronous active-high reset
//   clear                synchronous abort, same effect as reset
//   match_en             enable EtherType routing to out1
//   match_ethertype      EtherType that is routed to out1
//   in_data/src/dst_rdy  input stream (in_dst_rdy is driven by this block)
//   out0_* / out1_*      output streams (src_rdy/data driven by this block)
//
// Optional feature, macro ETH_RX_DISPATCH_STATS_EN:
//   Adds the counters stat_out0, stat_out1 and stat_drop (STATS_WIDTH bits,
//   wrapping). When the macro is undefined these ports do not exist.
// ---------------------------------------------------------------------------
module eth_rx_dispatch #(
  parameter int STATS_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        match_en,
  input  logic [15:0] match_ethertype,
  input  logic [35:0] in_data,
  input  logic        in_src_rdy,
  output logic        in_dst_rdy,
  output logic [35:0] out0_data,
  output logic        out0_src_rdy,
  input  logic        out0_dst_rdy,
  output logic [35:0] out1_data,
  output logic        out1_src_rdy,
  input  logic        out1_dst_rdy
`ifdef ETH_RX_DISPATCH_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] stat_out0,
  output logic [STATS_WIDTH-1:0] stat_out1,
  output logic [STATS_WIDTH-1:0] stat_drop
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR      = 2'd1,
    SEND_HDR = 2'd2,
    PASS     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [35:0] hdr [4];
  logic [1:0]  cnt;
  logic [1:0]  idx;
  logic        sel;
  logic        last;

  logic        in_sof;
  logic        in_eof;
  logic [1:0]  in_occ;
  logic        in_fire;
  logic        out_fire;
  logic        out_valid;
  logic [35:0] out_word;
  logic        sel_dst_rdy;
  logic        etype_runt;
  logic        hdr_done;

  assign in_sof      = in_data[32];
  assign in_eof      = in_data[33];
  assign in_occ      = in_data[35:34];
  assign sel_dst_rdy = sel ? out1_dst_rdy : out0_dst_rdy;
  assign in_fire     = in_src_rdy & in_dst_rdy;
  assign out_fire    = out_valid & sel_dst_rdy;

  // An eof on header word 3 carrying only one byte leaves the EtherType
  // incomplete, so such a frame is a runt.
  assign etype_runt  = in_eof & (in_occ == 2'd1);

  // Header word 3 accepted without restarting the frame: routing decision.
  assign hdr_done    = (state == HDR) & in_fire & ~in_sof & (cnt == 2'd3);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake/output selection. All outputs are held at zero
  // while reset or clear is asserted so that no transfer can happen then.
  always_comb begin
    state_nxt  = state;
    in_dst_rdy = 1'b0;
    out_word   = '0;
    out_valid  = 1'b0;
    if (!reset && !clear) begin
      case (state)
        IDLE: begin
          in_dst_rdy = 1'b1;
          if (in_fire && in_sof && !in_eof) begin
            state_nxt = HDR;
          end
        end
        HDR: begin
          in_dst_rdy = 1'b1;
          if (in_fire) begin
            if (in_sof) begin
              if (in_eof) begin
                state_nxt = IDLE;
              end
            end else if (cnt == 2'd3) begin
              state_nxt = etype_runt ? IDLE : SEND_HDR;
            end else if (in_eof) begin
              state_nxt = IDLE;
            end
          end
        end
        SEND_HDR: begin
          out_word  = hdr[idx];
          out_valid = 1'b1;
          if (out_fire && (idx == 2'd3)) begin
            state_nxt = last ? IDLE : PASS;
          end
        end
        PASS: begin
          out_word   = in_data;
          out_valid  = in_src_rdy;
          in_dst_rdy = sel_dst_rdy;
          if (out_fire && in_eof) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Only the selected output ever sees data; the other one stays at zero.
  assign out0_data    = sel ? '0 : out_word;
  assign out0_src_rdy = ~sel & out_valid;
  assign out1_data    = sel ? out_word : '0;
  assign out1_src_rdy = sel & out_valid;

  // Header buffer, word counter, replay index and the routing decision.
  // A sof seen while collecting restarts the buffer at hdr[0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        hdr[i] <= '0;
      end
      cnt  <= 2'd0;
      idx  <= 2'd0;
      sel  <= 1'b0;
      last <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < 4; i++) begin
        hdr[i] <= '0;
      end
      cnt  <= 2'd0;
      idx  <= 2'd0;
      sel  <= 1'b0;
      last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire && in_sof) begin
            hdr[0] <= in_data;
            cnt    <= 2'd1;
          end
        end
        HDR: begin
          if (in_fire) begin
            if (in_sof) begin
              hdr[0] <= in_data;
              cnt    <= 2'd1;
            end else begin
              hdr[cnt] <= in_data;
              cnt      <= cnt + 2'd1;
            end
          end
          // The EtherType is in the word being stored into hdr[3] right now.
          if (hdr_done && !etype_runt) begin
            sel  <= match_en & (in_data[31:16] == match_ethertype);
            last <= in_eof;
            idx  <= 2'd0;
          end
        end
        SEND_HDR: begin
          if (out_fire) begin
            idx <= idx + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ETH_RX_DISPATCH_STATS_EN
  logic [1:0] drop_inc;
  logic       orphan_run;

  // Drops in one accepted word: a runt (possibly two when a sof+eof word
  // interrupts a partial header) or the first word of an orphan run.
  always_comb begin
    drop_inc = 2'd0;
    if (in_fire) begin
      case (state)
        IDLE: begin
          if (in_sof) begin
            if (in_eof) begin
              drop_inc = 2'd1;
            end
          end else if (!orphan_run) begin
            drop_inc = 2'd1;
          end
        end
        HDR: begin
          if (in_sof) begin
            drop_inc = in_eof ? 2'd2 : 2'd1;
          end else if (in_eof && ((cnt != 2'd3) || (in_occ == 2'd1))) begin
            drop_inc = 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // orphan_run remembers that the previous accepted word was an orphan so
  // that a run of consecutive orphans counts as a single drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_out0  <= '0;
      stat_out1  <= '0;
      stat_drop  <= '0;
      orphan_run <= 1'b0;
    end else if (clear) begin
      stat_out0  <= '0;
      stat_out1  <= '0;
      stat_drop  <= '0;
      orphan_run <= 1'b0;
    end else begin
      if (out0_src_rdy && out0_dst_rdy && out0_data[33]) begin
        stat_out0 <= stat_out0 + 1'b1;
      end
      if (out1_src_rdy && out1_dst_rdy && out1_data[33]) begin
        stat_out1 <= stat_out1 + 1'b1;
      end
      stat_drop <= stat_drop + STATS_WIDTH'(drop_inc);
      if (in_fire) begin
        orphan_run <= (state == IDLE) & ~in_sof;
      end
    end
  end
`else
  localparam int unused_stats_width = STATS_WIDTH;
`endif

endmodule
